// File: rtl/cordic_rotation_core_if.sv
`default_nettype none
// ============================================================================
// Module   : cordic_rotation_core_if
// Brief    : Controller/ROM-side bus of the rotation-mode CORDIC core.
// Revision : 1.0 - initial release
// ============================================================================
interface cordic_rotation_core_if #(
    parameter int WORD_LENGTH    = 16,
    parameter int ADDRESS_LENGTH = 4
);
    logic                             start;
    logic signed [WORD_LENGTH-1:0]    x_in;
    logic signed [WORD_LENGTH-1:0]    y_in;
    logic signed [WORD_LENGTH-1:0]    z_in;
    logic        [ADDRESS_LENGTH-1:0] rom_address;
    logic signed [WORD_LENGTH-1:0]    rom_data;
    logic signed [WORD_LENGTH-1:0]    x_out;
    logic signed [WORD_LENGTH-1:0]    y_out;
    logic signed [WORD_LENGTH-1:0]    z_out;
    logic                             busy;
    logic                             done;

    // The master side also hosts the shared arctangent ROM, hence it drives rom_data.
    modport master (
        output start, x_in, y_in, z_in, rom_data,
        input  rom_address, x_out, y_out, z_out, busy, done
    );

    modport slave (
        input  start, x_in, y_in, z_in, rom_data,
        output rom_address, x_out, y_out, z_out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/cordic_rotation_core.sv
`default_nettype none
// ============================================================================
// Module   : cordic_rotation_core
// Brief    : Iterative rotation-mode CORDIC, one micro-rotation per clock,
//            start/busy/done handshake, external combinational atan ROM.
//            Optional macro CORDIC_QUADRANT_EXT_EN folds |z| > pi/2 at load.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_rotation_core #(
    parameter int WORD_LENGTH    = 16,
    parameter int ADDRESS_LENGTH = 4,
    parameter int ITERATIONS     = 16,
    parameter int FRAC_BITS      = 13
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    cordic_rotation_core_if.slave core_bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [ADDRESS_LENGTH-1:0] c_iter_last = ADDRESS_LENGTH'(ITERATIONS - 1);

    if (ITERATIONS < 1 || ITERATIONS > (1 << ADDRESS_LENGTH)) begin : g_bad_iterations
        $error("cordic_rotation_core: ITERATIONS out of range for ADDRESS_LENGTH");
    end
    if (FRAC_BITS < 1 || FRAC_BITS > WORD_LENGTH - 2) begin : g_bad_frac_bits
        $error("cordic_rotation_core: FRAC_BITS must leave room for two integer bits");
    end

    state_t                             state_q, state_d;
    logic        [ADDRESS_LENGTH-1:0]   iter_q, iter_d;
    logic signed [WORD_LENGTH-1:0]      x_q, x_d;
    logic signed [WORD_LENGTH-1:0]      y_q, y_d;
    logic signed [WORD_LENGTH-1:0]      z_q, z_d;
    logic signed [WORD_LENGTH-1:0]      xo_q, xo_d;
    logic signed [WORD_LENGTH-1:0]      yo_q, yo_d;
    logic signed [WORD_LENGTH-1:0]      zo_q, zo_d;

    logic signed [WORD_LENGTH-1:0]      w_x_ld, w_y_ld, w_z_ld;
    logic signed [WORD_LENGTH-1:0]      w_x_sh, w_y_sh;
    logic signed [WORD_LENGTH-1:0]      w_x_rot, w_y_rot, w_z_rot;
    logic                               w_dir_pos;

`ifdef CORDIC_QUADRANT_EXT_EN
    // pi and pi/2 in Q(FRAC_BITS), derived from their Q2.13 values 25736 / 12868.
    localparam longint c_pi_int      = (64'sd25736 * (64'sd1 <<< FRAC_BITS)) / 64'sd8192;
    localparam longint c_half_pi_int = (64'sd12868 * (64'sd1 <<< FRAC_BITS)) / 64'sd8192;
    localparam logic signed [WORD_LENGTH-1:0] c_pi      = WORD_LENGTH'(c_pi_int);
    localparam logic signed [WORD_LENGTH-1:0] c_half_pi = WORD_LENGTH'(c_half_pi_int);

    // Rotating by +-pi negates the vector, so fold the angle into [-pi/2, pi/2].
    always_comb begin
        w_x_ld = core_bus.x_in;
        w_y_ld = core_bus.y_in;
        w_z_ld = core_bus.z_in;
        if (core_bus.z_in > c_half_pi) begin
            w_x_ld = -core_bus.x_in;
            w_y_ld = -core_bus.y_in;
            w_z_ld = core_bus.z_in - c_pi;
        end else if (core_bus.z_in < -c_half_pi) begin
            w_x_ld = -core_bus.x_in;
            w_y_ld = -core_bus.y_in;
            w_z_ld = core_bus.z_in + c_pi;
        end
    end
`else
    always_comb begin
        w_x_ld = core_bus.x_in;
        w_y_ld = core_bus.y_in;
        w_z_ld = core_bus.z_in;
    end
`endif

    always_comb begin
        w_dir_pos = ~z_q[WORD_LENGTH-1];
        w_x_sh    = x_q >>> iter_q;
        w_y_sh    = y_q >>> iter_q;
        w_x_rot   = w_dir_pos ? (x_q - w_y_sh)            : (x_q + w_y_sh);
        w_y_rot   = w_dir_pos ? (y_q + w_x_sh)            : (y_q - w_x_sh);
        w_z_rot   = w_dir_pos ? (z_q - core_bus.rom_data) : (z_q + core_bus.rom_data);
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;

        unique case (state_q)
            S_IDLE: begin
                if (core_bus.start) begin
                    x_d     = w_x_ld;
                    y_d     = w_y_ld;
                    z_d     = w_z_ld;
                    iter_d  = '0;
                    state_d = S_ROTATE;
                end
            end
            S_ROTATE: begin
                x_d    = w_x_rot;
                y_d    = w_y_rot;
                z_d    = w_z_rot;
                iter_d = iter_q + 1'b1;
                if (iter_q == c_iter_last) begin
                    xo_d    = w_x_rot;
                    yo_d    = w_y_rot;
                    zo_d    = w_z_rot;
                    iter_d  = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                iter_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    assign core_bus.rom_address = (state_q == S_ROTATE) ? iter_q : '0;
    assign core_bus.busy        = (state_q != S_IDLE);
    assign core_bus.done        = (state_q == S_DONE);
    assign core_bus.x_out       = xo_q;
    assign core_bus.y_out       = yo_q;
    assign core_bus.z_out       = zo_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_rotation_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_rotation_core
// Brief    : Self-checking bench for cordic_rotation_core: behavioural model,
//            per-cycle compare, literal trig expectations, random operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_rotation_core;
    localparam int W = 16;
    localparam int A = 4;
    localparam int N = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   checking;

    cordic_rotation_core_if #(.WORD_LENGTH(W), .ADDRESS_LENGTH(A)) bus ();

    cordic_rotation_core #(
        .WORD_LENGTH(W), .ADDRESS_LENGTH(A), .ITERATIONS(N), .FRAC_BITS(13)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .core_bus (bus.slave)
    );

    // atan(2^-i) in Q2.13, rounded to nearest.
    logic signed [W-1:0] atan_tab [0:N-1] = '{
        16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019, 16'sd511, 16'sd256, 16'sd128, 16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4,    16'sd2,   16'sd1,   16'sd0,   16'sd0
    };
    assign bus.rom_data = atan_tab[bus.rom_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3*W-1:0] model(input logic signed [W-1:0] xi, yi, zi);
        logic signed [W-1:0] x, y, z, xs, ys;
        x = xi;
        y = yi;
        z = zi;
`ifdef CORDIC_QUADRANT_EXT_EN
        if (zi > 16'sd12868) begin
            x = -xi; y = -yi; z = zi - 16'sd25736;
        end else if (zi < -16'sd12868) begin
            x = -xi; y = -yi; z = zi + 16'sd25736;
        end
`endif
        for (int i = 0; i < N; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (z >= 0) begin
                x = x - ys; y = y + xs; z = z - atan_tab[i];
            end else begin
                x = x + ys; y = y - xs; z = z + atan_tab[i];
            end
        end
        return {x, y, z};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_near(input string name, input longint act, input longint exp, input longint tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +-%0d", name, act, exp, tol);
        end
    endtask

    // Operation-level model: cycles remaining until idle, pending and visible results.
    int                  m_cnt;
    logic [3*W-1:0]      m_pend;
    logic signed [W-1:0] e_x, e_y, e_z;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            e_x   <= '0;
            e_y   <= '0;
            e_z   <= '0;
        end else if (m_cnt == 0) begin
            if (bus.start) begin
                m_pend <= model(bus.x_in, bus.y_in, bus.z_in);
                m_cnt  <= N + 1;
            end
        end else begin
            if (m_cnt == 2) begin
                e_x <= m_pend[3*W-1:2*W];
                e_y <= m_pend[2*W-1:W];
                e_z <= m_pend[W-1:0];
            end
            m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("busy",        longint'(bus.busy), longint'(m_cnt != 0));
            chk("done",        longint'(bus.done), longint'(m_cnt == 1));
            chk("rom_address", longint'(bus.rom_address), (m_cnt >= 2) ? longint'(N + 1 - m_cnt) : 64'd0);
            chk("x_out",       longint'(bus.x_out), longint'(e_x));
            chk("y_out",       longint'(bus.y_out), longint'(e_y));
            chk("z_out",       longint'(bus.z_out), longint'(e_z));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic signed [W-1:0] x, y, z, input bit noise, output int lat);
        logic [3*W-1:0] mo;
        mo = model(x, y, z);
        wait_idle();
        bus.x_in  = x;
        bus.y_in  = y;
        bus.z_in  = z;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.x_in  = W'($urandom);
        bus.y_in  = W'($urandom);
        bus.z_in  = W'($urandom);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                bus.start = 1'b0;
                break;
            end
            if (noise) bus.start = 1'($urandom);
        end
        bus.start = 1'b0;
        if (lat == 0) chk("done_timeout", 0, 1);
        chk("op_result_x", longint'(bus.x_out), longint'($signed(mo[3*W-1:2*W])));
        chk("op_result_y", longint'(bus.y_out), longint'($signed(mo[2*W-1:W])));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int             lat;
        int             pulses, high_cycles, first_at, second_at;
        bit             prev_done;
        logic [3*W-1:0] mo;
        int             zr;

        checks    = 0;
        errors    = 0;
        checking  = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;
        bus.z_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        chk("reset_busy", longint'(bus.busy), 0);
        chk("reset_x_out", longint'(bus.x_out), 0);
        rst_n = 1'b1;

        mo = model(16'sd4975, 16'sd0, 16'sd6434);
        chk_near("model_pi4_x", longint'($signed(mo[3*W-1:2*W])), 5793, 4);
        chk_near("model_pi4_y", longint'($signed(mo[2*W-1:W])), 5793, 4);

        run_op(16'sd4975, 16'sd0, 16'sd0, 1'b0, lat);
        chk("latency_z0", lat, 17);
        chk_near("z0_x", longint'(bus.x_out), 8192, 4);
        chk_near("z0_y", longint'(bus.y_out), 0, 4);
        chk_near("z0_z", longint'(bus.z_out), 0, 4);

        run_op(16'sd4975, 16'sd0, 16'sd6434, 1'b1, lat);
        chk("latency_pi4", lat, 17);
        chk_near("pi4_x", longint'(bus.x_out), 5793, 4);
        chk_near("pi4_y", longint'(bus.y_out), 5793, 4);

        run_op(16'sd4975, 16'sd0, -16'sd4289, 1'b1, lat);
        chk_near("mpi6_x", longint'(bus.x_out), 7094, 4);
        chk_near("mpi6_y", longint'(bus.y_out), -4096, 4);

        run_op(16'sd4975, 16'sd0, 16'sd14281, 1'b0, lat);
        chk("latency_edge", lat, 17);

`ifdef CORDIC_QUADRANT_EXT_EN
        run_op(16'sd4975, 16'sd0, 16'sd19302, 1'b0, lat);
        chk_near("q3pi4_x", longint'(bus.x_out), -5793, 4);
        chk_near("q3pi4_y", longint'(bus.y_out), 5793, 4);
        run_op(16'sd4975, 16'sd0, -16'sd19302, 1'b0, lat);
        chk_near("qm3pi4_x", longint'(bus.x_out), -5793, 4);
        chk_near("qm3pi4_y", longint'(bus.y_out), -5793, 4);
`endif

        // Asynchronous reset in the middle of an operation.
        wait_idle();
        bus.x_in  = 16'sd3000;
        bus.y_in  = 16'sd1000;
        bus.z_in  = 16'sd5000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", longint'(bus.busy), 0);
        chk("midrst_done", longint'(bus.done), 0);
        chk("midrst_addr", longint'(bus.rom_address), 0);
        chk("midrst_x", longint'(bus.x_out), 0);
        chk("midrst_y", longint'(bus.y_out), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(16'sd4975, 16'sd0, 16'sd6434, 1'b0, lat);
        chk("after_rst_latency", lat, 17);
        chk_near("after_rst_x", longint'(bus.x_out), 5793, 4);

        // Start held high: accepts at the first idle edge after each done.
        wait_idle();
        bus.x_in   = 16'sd4975;
        bus.y_in   = 16'sd0;
        bus.z_in   = 16'sd0;
        bus.start  = 1'b1;
        pulses     = 0;
        high_cycles = 0;
        first_at   = -1;
        second_at  = -1;
        prev_done  = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done) high_cycles++;
            if (bus.done && !prev_done) begin
                pulses++;
                if (first_at < 0) first_at = k;
                else if (second_at < 0) second_at = k;
            end
            prev_done = bus.done;
            if (k == 35) bus.start = 1'b0;
        end
        chk("held_pulses", pulses, 2);
        chk("held_high_cycles", high_cycles, 2);
        chk("held_spacing", second_at - first_at, 18);

        for (int r = 0; r < 30; r++) begin
`ifdef CORDIC_QUADRANT_EXT_EN
            zr = int'($urandom_range(0, 51472)) - 25736;
`else
            zr = int'($urandom_range(0, 28562)) - 14281;
`endif
            run_op(W'(int'($urandom_range(0, 10000)) - 5000),
                   W'(int'($urandom_range(0, 10000)) - 5000),
                   W'(zr), 1'($urandom), lat);
            chk("rand_latency", lat, 17);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        wait_idle();
        repeat (2) @(posedge clk);
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
